// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Byte-wide memory bus slave. Byte-addressed RAM plus an IO
//               window at addr[17:16]==2'b11 holding a TX FIFO, a one-byte RX
//               holding register, a status byte and a sticky halt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int RAM_ADDR_BITS = 17,
  parameter int TX_DEPTH      = 8,
  parameter int FULL_MARGIN   = 2
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] mem_aout,
  input  logic [7:0]            mem_dout,
  input  logic                  mem_rw,
  output logic [7:0]            mem_din,
  output logic                  io_buffer_full,
  output logic [7:0]            io_tx_data,
  output logic                  io_tx_valid,
  input  logic                  io_tx_ready,
  input  logic [7:0]            io_rx_data,
  input  logic                  io_rx_valid,
  output logic                  io_rx_ready,
  output logic                  io_halt
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] TX_FULL_CNT = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEVEL  = CNT_W'(TX_DEPTH - FULL_MARGIN);

  logic [7:0]             ram [0:(2**RAM_ADDR_BITS)-1];
  logic [7:0]             tx_mem [0:TX_DEPTH-1];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       tx_count;
  logic [CNT_W-1:0]       tx_count_nxt;
  logic                   rx_full;
  logic [7:0]             rx_byte;

  logic                   io_sel;
  logic [2:0]             io_off;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic [7:0]             ram_rd;
  logic                   ram_we;
  logic                   tx_push;
  logic                   tx_pop;
  logic                   rx_pop;
  logic                   rx_capture;
  logic                   halt_set;
  logic                   unused_addr_hi;

  // Address bits above the IO select field never take part in decoding.
  assign unused_addr_hi = ^mem_aout[ADDR_WIDTH-1:18];

  assign io_sel  = (mem_aout[17:16] == 2'b11);
  assign io_off  = mem_aout[2:0];
  assign ram_idx = mem_aout[RAM_ADDR_BITS-1:0];
  assign ram_rd  = ram[ram_idx];

  assign io_tx_valid = (tx_count != '0);
  assign io_tx_data  = tx_mem[rd_ptr];
  assign io_rx_ready = !rx_full;

  // Bus-side strobes (all gated by rdy_in) and the free-running drain/capture.
  always_comb begin
    ram_we     = rdy_in && mem_rw && !io_sel;
    tx_pop     = io_tx_valid && io_tx_ready;
    tx_push    = rdy_in && mem_rw && io_sel && (io_off == 3'd0)
                 && ((tx_count != TX_FULL_CNT) || tx_pop);
    halt_set   = rdy_in && mem_rw && io_sel && (io_off == 3'd4);
    rx_pop     = rdy_in && !mem_rw && io_sel && (io_off == 3'd0);
    // A pop of a full register frees it in the same cycle, so a new byte lands.
    rx_capture = io_rx_valid && (!rx_full || rx_pop);
    tx_count_nxt = tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
  end

  // RAM write port; contents survive reset but no write occurs while in reset.
  always_ff @(posedge clk) begin
    if (rst_in && ram_we) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  // TX FIFO storage (no reset needed, validity is tracked by tx_count).
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[wr_ptr] <= mem_dout;
    end
  end

  // TX pointers, occupancy and the registered almost-full flag.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tx_count       <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      tx_count       <= tx_count_nxt;
      io_buffer_full <= (tx_count_nxt >= FULL_LEVEL);
    end
  end

  // RX holding register: capture from host, cleared by a DATA read.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
    end else if (rx_capture) begin
      rx_full <= 1'b1;
      rx_byte <= io_rx_data;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

  // Sticky halt flag.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      io_halt <= 1'b0;
    end else if (halt_set) begin
      io_halt <= 1'b1;
    end
  end

  // Registered read data; holds while rdy_in is low, zero after any write.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      mem_din <= 8'h00;
    end else if (rdy_in) begin
      if (mem_rw) begin
        mem_din <= 8'h00;
      end else if (!io_sel) begin
        mem_din <= ram_rd;
      end else begin
        case (io_off)
          3'd0:    mem_din <= rx_full ? rx_byte : 8'h00;
          3'd4:    mem_din <= {6'b0, rx_full, io_buffer_full};
          default: mem_din <= 8'h00;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Read data and TX bytes
//               are checked against queues filled when stimulus is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_aout;
  logic [7:0]  mem_dout;
  logic        mem_rw;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready;
  logic        io_halt;

  logic        chk_rd;
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;

  mem_responder dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_aout       (mem_aout),
    .mem_dout       (mem_dout),
    .mem_rw         (mem_rw),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .io_tx_data     (io_tx_data),
    .io_tx_valid    (io_tx_valid),
    .io_tx_ready    (io_tx_ready),
    .io_rx_data     (io_rx_data),
    .io_rx_valid    (io_rx_valid),
    .io_rx_ready    (io_rx_ready),
    .io_halt        (io_halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 2 time units after posedge; outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    rdy_in = 1'b1; mem_rw = 1'b1; mem_aout = a; mem_dout = d; chk_rd = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    rdy_in = 1'b1; mem_rw = 1'b0; mem_aout = a; chk_rd = 1'b1;
    rd_q.push_back(exp);
    tick();
  endtask

  task automatic tx_wr(input logic [7:0] d, input bit accept);
    if (accept) tx_q.push_back(d);
    wr(32'h0003_0000, d);
  endtask

  task automatic idle();
    rdy_in = 1'b1; mem_rw = 1'b0; mem_aout = '0; chk_rd = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: read data one cycle after a tracked read, TX on handshake.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
      else chk("rd_data", {24'h0, mem_din}, {24'h0, rd_q.pop_front()});
    end
    rd_pend = rst_in && rdy_in && !mem_rw && chk_rd;
    if (rst_in && io_tx_valid && io_tx_ready) begin
      if (tx_q.size() == 0) chk("tx_q_underflow", {24'h0, io_tx_data}, 32'hFFFF_FFFF);
      else chk("tx_data", {24'h0, io_tx_data}, {24'h0, tx_q.pop_front()});
    end
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; mem_aout = '0; mem_dout = '0; mem_rw = 1'b0;
    io_tx_ready = 1'b0; io_rx_data = '0; io_rx_valid = 1'b0; chk_rd = 1'b0;
    tick(); tick();
    chk("rst_mem_din", {24'h0, mem_din}, 0);
    chk("rst_full", {31'h0, io_buffer_full}, 0);
    chk("rst_tx_valid", {31'h0, io_tx_valid}, 0);
    chk("rst_rx_ready", {31'h0, io_rx_ready}, 1);
    chk("rst_halt", {31'h0, io_halt}, 0);
    rst_in = 1'b1;
    tick();

    // 1: write then immediate read-back; high address bits ignored
    wr(32'h0000_0010, 8'hA5);
    rd(32'h0000_0010, 8'hA5);
    rd(32'h0004_0010, 8'hA5);
    // 2: back-to-back reads, no bubble
    wr(32'h0, 8'h11); wr(32'h1, 8'h22); wr(32'h2, 8'h33); wr(32'h3, 8'h44);
    rd(32'h0, 8'h11); rd(32'h1, 8'h22); rd(32'h2, 8'h33); rd(32'h3, 8'h44);
    idle();

    // 3: fill TX FIFO with drain stalled, check flag, overflow drop, push+pop when full
    for (int i = 0; i < 8; i++) begin
      tx_wr(8'h41 + 8'(i), 1'b1);
      if (i == 4) chk("full_after5", {31'h0, io_buffer_full}, 0);
      if (i == 5) chk("full_after6", {31'h0, io_buffer_full}, 1);
    end
    tx_wr(8'h49, 1'b0);
    chk("tx_valid_full", {31'h0, io_tx_valid}, 1);
    io_tx_ready = 1'b1;
    tx_wr(8'h50, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    chk("tx_drained", {31'h0, io_tx_valid}, 0);
    chk("full_cleared", {31'h0, io_buffer_full}, 0);
    chk("tx_q_empty", tx_q.size(), 0);

    // 4: RX capture, status, pop, reread, other offset, capture+pop corner
    io_rx_valid = 1'b1; io_rx_data = 8'h5A;
    idle();
    io_rx_valid = 1'b0;
    chk("rx_ready_full", {31'h0, io_rx_ready}, 0);
    rd(32'h0003_0004, 8'h02);
    rd(32'h0003_0002, 8'h00);
    rd(32'h0003_0000, 8'h5A);
    rd(32'h0003_0000, 8'h00);
    chk("rx_ready_empty", {31'h0, io_rx_ready}, 1);
    io_rx_valid = 1'b1; io_rx_data = 8'h11;
    idle();
    io_rx_data = 8'h77;
    rd(32'h0003_0000, 8'h11);
    io_rx_valid = 1'b0;
    chk("rx_recapture", {31'h0, io_rx_ready}, 0);
    rd(32'h0003_0000, 8'h77);
    wr(32'h0003_0006, 8'hEE);
    chk("odd_off_halt", {31'h0, io_halt}, 0);
    chk("odd_off_tx", {31'h0, io_tx_valid}, 0);

    // 5: rdy_in low freezes bus side; halt set and sticky
    wr(32'h20, 8'h3C);
    rd(32'h20, 8'h3C);
    rdy_in = 1'b0; mem_rw = 1'b1; mem_aout = 32'h20; mem_dout = 8'h99; chk_rd = 1'b0;
    tick();
    chk("stall_din_hold", {24'h0, mem_din}, 32'h3C);
    mem_aout = 32'h0003_0004;
    tick();
    chk("stall_no_halt", {31'h0, io_halt}, 0);
    rd(32'h20, 8'h3C);
    wr(32'h0003_0004, 8'h00);
    chk("halt_set", {31'h0, io_halt}, 1);
    idle(); idle(); idle();
    chk("halt_sticky", {31'h0, io_halt}, 1);

    // 6: async reset mid TX burst
    wr(32'h40, 8'h6D);
    io_tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) tx_wr(8'hC0 + 8'(i), 1'b1);
    chk("burst_full", {31'h0, io_buffer_full}, 1);
    rd(32'h40, 8'h6D);
    mem_rw = 1'b0; chk_rd = 1'b0; mem_aout = '0;
    @(negedge clk);
    #1 rst_in = 1'b0;
    #1;
    chk("arst_tx_valid", {31'h0, io_tx_valid}, 0);
    chk("arst_full", {31'h0, io_buffer_full}, 0);
    chk("arst_mem_din", {24'h0, mem_din}, 0);
    chk("arst_halt", {31'h0, io_halt}, 0);
    tx_q.delete();
    tick(); tick();
    rst_in = 1'b1;
    io_tx_ready = 1'b1;
    rd(32'h40, 8'h6D);
    idle(); idle();
    chk("post_rst_tx", {31'h0, io_tx_valid}, 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
